// File: rtl/dec_pkg.sv
// dec_pkg: mode/state encodings and sizing helper shared by the scan decoder
package dec_pkg;
   localparam logic [1:0] MODE_DIRECT = 2'b00;
   localparam logic [1:0] MODE_SCAN   = 2'b01;
   localparam logic [1:0] MODE_SWEEP  = 2'b10;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   function automatic int cnt_width(input int dwell);
      return (dwell > 1) ? $clog2(dwell) : 1;
   endfunction
endpackage

// File: rtl/dec_onehot.sv
// dec_onehot: combinational N-bit index to 2**N one-hot map, gated by en
module dec_onehot #(
   parameter int N = 4
) (
   input  logic [N-1:0]    idx,
   input  logic            en,
   output logic [2**N-1:0] oh
);
   localparam int W = 2**N;
   localparam logic [W-1:0] ONE = W'(1);
   assign oh = en ? ONE << idx : '0;
endmodule

// File: rtl/dec_scan_seq.sv
// dec_scan_seq: registered N-to-2**N one-hot decoder with direct, scan and sweep modes
module dec_scan_seq
   import dec_pkg::*;
#(
   parameter int N     = 4,
   parameter int DWELL = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic [1:0]      mode,
   input  logic [N-1:0]    sel,
   input  logic [N-1:0]    last,
   input  logic            start,
   input  logic            stop,
   output logic [2**N-1:0] out,
   output logic [N-1:0]    idx,
   output logic            busy,
   output logic            done
);
   localparam int W  = 2**N;
   localparam int CW = cnt_width(DWELL);
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL-1);
   logic [1:0]    state, nxt_state, mode_q, nxt_mode;
   logic [N-1:0]  last_q, nxt_last, nxt_idx;
   logic [CW-1:0] cnt, nxt_cnt;
   logic          nxt_on, accept, expire, at_end;
   logic [W-1:0]  nxt_out;
   assign accept = en && start && !stop && (mode == MODE_SCAN || mode == MODE_SWEEP);
   assign expire = en && cnt == CNT_LAST;
   assign at_end = idx >= last_q;
   assign busy   = state == ST_RUN;
   assign done   = state == ST_DONE;
   // everything funnels into one next-index/enable pair so a single decoder feeds out
   always_comb begin
      nxt_state = state;
      nxt_mode  = mode_q;
      nxt_last  = last_q;
      nxt_idx   = idx;
      nxt_cnt   = cnt;
      nxt_on    = 1'b0;
      case (state)
         ST_RUN:
            if (stop) begin
               nxt_state = ST_IDLE;
               nxt_idx   = '0;
               nxt_cnt   = '0;
            end else if (expire && at_end && mode_q == MODE_SWEEP) begin
               nxt_state = ST_DONE;
               nxt_cnt   = '0;
            end else if (en) begin
               nxt_on  = 1'b1;
               nxt_cnt = expire ? '0 : cnt + CW'(1);
               nxt_idx = !expire ? idx : at_end ? '0 : idx + N'(1);
            end
         default:
            if (state == ST_IDLE && accept) begin
               nxt_state = ST_RUN;
               nxt_mode  = mode;
               nxt_last  = last;
               nxt_idx   = '0;
               nxt_cnt   = '0;
               nxt_on    = 1'b1;
            end else begin
               nxt_state = ST_IDLE;
               nxt_idx   = sel;
               nxt_on    = en;
            end
      endcase
   end
   dec_onehot #(.N(N)) u_oh (.idx(nxt_idx), .en(nxt_on), .oh(nxt_out));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         mode_q <= MODE_DIRECT;
         last_q <= '0;
         idx    <= '0;
         cnt    <= '0;
         out    <= '0;
      end else begin
         state  <= nxt_state;
         mode_q <= nxt_mode;
         last_q <= nxt_last;
         idx    <= nxt_idx;
         cnt    <= nxt_cnt;
         out    <= nxt_out;
      end
   end
endmodule

// File: tb/tb_dec_scan_seq.sv
// tb_dec_scan_seq: directed scoreboard bench for dec_scan_seq at N=4, DWELL=2
module tb_dec_scan_seq;
   typedef struct packed {
      logic [15:0] o;
      logic [3:0]  i;
      logic        ic;
      logic        b;
      logic        d;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst_n, en, start, stop, busy, done;
   logic [1:0]  mode;
   logic [3:0]  sel, last, idx;
   logic [15:0] out;
   exp_t        q[$];
   string       tq[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   always #5 clk = ~clk;
   dec_scan_seq #(.N(4), .DWELL(2)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .last(last),
      .start(start), .stop(stop), .out(out), .idx(idx), .busy(busy), .done(done)
   );
   function automatic logic [15:0] oh(input int i);
      logic [15:0] one;
      one = 16'h0001;
      return one << i;
   endfunction
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
      n_cmp++;
      assert (got === want) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask
   task automatic expect_(input logic [15:0] o, input int i, input logic b, input logic d, input string t);
      exp_t e;
      e.o  = o;
      e.i  = 4'(i);
      e.ic = i >= 0;
      e.b  = b;
      e.d  = d;
      q.push_back(e);
      tq.push_back(t);
   endtask
   task automatic check_front();
      exp_t  e;
      string t;
      e = q.pop_front();
      t = tq.pop_front();
      chk({t, "/out"}, out, e.o);
      if (e.ic) chk({t, "/idx"}, 16'(idx), 16'(e.i));
      chk({t, "/busy"}, 16'(busy), 16'(e.b));
      chk({t, "/done"}, 16'(done), 16'(e.d));
   endtask
   task automatic step(input logic [15:0] o, input int i, input logic b, input logic d, input string t);
      expect_(o, i, b, d, t);
      @(posedge clk);
      #1;
      check_front();
   endtask
   task automatic now_(input logic [15:0] o, input int i, input logic b, input logic d, input string t);
      expect_(o, i, b, d, t);
      check_front();
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "timeout");
   end
   initial begin
      automatic int dsel[5] = '{2, 5, 7, 14, 12};
      rst_n = 1'b0; en = 1'b0; mode = 2'b00; sel = 4'd0; last = 4'd0; start = 1'b0; stop = 1'b0;
      #3 now_(16'h0, 0, 1'b0, 1'b0, "reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      // direct decode, en low then a handful of indices
      step(16'h0, 0, 1'b0, 1'b0, "dir_en0_s0");
      sel = 4'd8;
      step(16'h0, 8, 1'b0, 1'b0, "dir_en0_s8");
      en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         sel = 4'(dsel[k]);
         step(oh(dsel[k]), dsel[k], 1'b0, 1'b0, "dir");
      end
      // scan last=3; mid-run last change and start pulse must be ignored
      mode = 2'b01; last = 4'd3; start = 1'b1; sel = 4'd9;
      step(16'h0001, 0, 1'b1, 1'b0, "scan_start");
      start = 1'b0; mode = 2'b00; sel = 4'd5;
      for (int k = 1; k <= 11; k++) begin
         if (k == 3) begin last = 4'd1; start = 1'b1; end
         if (k == 4) start = 1'b0;
         step(oh((k / 2) % 4), (k / 2) % 4, 1'b1, 1'b0, "scan");
      end
      // stop coincides with dwell expiry
      stop = 1'b1; last = 4'd3; sel = 4'd3;
      step(16'h0, 0, 1'b0, 1'b0, "stop_expire");
      stop = 1'b0;
      step(16'h0008, 3, 1'b0, 1'b0, "after_stop");
      mode = 2'b01; start = 1'b1; stop = 1'b1; sel = 4'd6;
      step(16'h0040, 6, 1'b0, 1'b0, "start_stop");
      mode = 2'b11; stop = 1'b0; sel = 4'd1;
      step(16'h0002, 1, 1'b0, 1'b0, "mode11_start");
      // one sweep over 0..2 then a done pulse
      mode = 2'b10; last = 4'd2; sel = 4'd4;
      step(16'h0001, 0, 1'b1, 1'b0, "sweep_start");
      start = 1'b0; mode = 2'b00;
      for (int k = 1; k <= 5; k++) step(oh(k / 2), k / 2, 1'b1, 1'b0, "sweep");
      step(16'h0, -1, 1'b0, 1'b1, "sweep_done");
      step(16'h0010, 4, 1'b0, 1'b0, "sweep_idle");
      mode = 2'b10; last = 4'd0; start = 1'b1; sel = 4'd15;
      step(16'h0001, 0, 1'b1, 1'b0, "sw0_start");
      start = 1'b0;
      step(16'h0001, 0, 1'b1, 1'b0, "sw0_hold");
      step(16'h0, -1, 1'b0, 1'b1, "sw0_done");
      step(16'h8000, 15, 1'b0, 1'b0, "sw0_idle");
      // pause during the first cycle of idx=1
      mode = 2'b01; last = 4'd3; start = 1'b1;
      step(16'h0001, 0, 1'b1, 1'b0, "pause_start");
      start = 1'b0;
      step(16'h0001, 0, 1'b1, 1'b0, "pause_i0");
      step(16'h0002, 1, 1'b1, 1'b0, "pause_i1");
      en = 1'b0;
      for (int k = 0; k < 3; k++) step(16'h0, 1, 1'b1, 1'b0, "paused");
      en = 1'b1;
      step(16'h0002, 1, 1'b1, 1'b0, "resume_i1");
      step(16'h0004, 2, 1'b1, 1'b0, "resume_i2");
      stop = 1'b1;
      step(16'h0, 0, 1'b0, 1'b0, "pause_stop");
      stop = 1'b0;
      // asynchronous reset between edges mid-sweep
      mode = 2'b10; last = 4'd3; start = 1'b1;
      step(16'h0001, 0, 1'b1, 1'b0, "rst_sw_start");
      start = 1'b0;
      step(16'h0001, 0, 1'b1, 1'b0, "rst_sw_i0");
      step(16'h0002, 1, 1'b1, 1'b0, "rst_sw_i1");
      #2 rst_n = 1'b0;
      #1 now_(16'h0, 0, 1'b0, 1'b0, "async_rst");
      @(negedge clk);
      rst_n = 1'b1; mode = 2'b00; sel = 4'd11;
      step(16'h0800, 11, 1'b0, 1'b0, "post_rst");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/dec_scan_seq.md
Name: dec_scan_seq

Overview:
- Parametrised successor to the 4-to-16 enable decoder: registered N-to-2^N one-hot decoder with three modes.
- Direct mode: registered decode of sel.
- Scan mode: free-running sweep over outputs 0..last, each held DWELL cycles.
- Sweep mode: one sweep over outputs 0..last, then a done pulse.
- Drives digit/row strobes for multiplexed displays and keypads.

Parameters:
N, 4, select width; output width is 2**N.
DWELL, 4, clock cycles each index is held in scan/sweep modes (>=1).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  global enable; low forces out to 0 and pauses sequencing.
mode  input  2  00 direct, 01 scan, 10 sweep, 11 reserved (treated as direct).
sel  input  N  index decoded in direct mode.
last  input  N  final index of scan/sweep; sampled on accepted start.
start  input  1  begins scan/sweep when accepted.
stop  input  1  aborts scan/sweep.
out  output  2**N  registered one-hot strobe, or all zeros.
idx  output  N  index currently driven (registered).
busy  output  1  high while state is RUN.
done  output  1  one-cycle pulse at end of sweep.

Behaviour:
- Reset (async, rst_n low): out=0, idx=0, busy=0, done=0, state=IDLE, dwell counter=0, last_q=0, mode_q=direct. Takes effect immediately, also mid-sweep.
- States:
  - IDLE: direct decode.
  - RUN: sequencing.
  - DONE: single cycle; drives the done pulse.
- IDLE behaviour:
  - Each edge: out <= en ? (1<<sel) : 0; idx <= sel.
  - Latency 1 clock. busy=0.
- Start acceptance:
  - Condition: state=IDLE, en=1, start=1, stop=0, mode in {01,10}.
  - On the accepting edge: mode_q<=mode, last_q<=last, idx<=0, out<=1, dwell counter<=0, state<=RUN.
  - start in any other state is ignored. stop=1 with start=1 in IDLE: stop wins, no start.
- RUN behaviour:
  - sel, mode and last are ignored; only mode_q and last_q apply.
  - Each index is visible on out for exactly DWELL en-high cycles.
  - Dwell counter counts 0..DWELL-1. At DWELL-1:
    - idx < last_q: idx+1.
    - idx == last_q, mode_q=scan: idx wraps to 0.
    - idx == last_q, mode_q=sweep: state<=DONE, out<=0.
  - last_q=0: scan holds idx 0 forever; sweep lasts DWELL cycles.
- en low in RUN:
  - Next edge out<=0. idx, dwell counter and state frozen.
  - On en return, out<=1<<idx on the next edge; the remaining dwell count resumes.
- stop in RUN: next edge state<=IDLE, out<=0, idx<=0, no done pulse. stop takes priority over dwell expiry in the same cycle.
- DONE: done=1, busy=0, out=0 for that one cycle; next edge state<=IDLE and direct decode resumes.
- Invariants: out is always all-zero or one-hot. busy is high exactly when state=RUN.

Decomposition:
- Shared package dec_pkg: mode encodings (MODE_DIRECT, MODE_SCAN, MODE_SWEEP) and state encodings (ST_IDLE, ST_RUN, ST_DONE).
- Sub-module dec_onehot: combinational, parameter N, maps an N-bit index plus enable to a 2**N one-hot value. Reused for both direct and sequenced paths.
- Dwell counter width: clog2(DWELL), minimum 1 bit.

Test Plan:
- N=4, DWELL=2. Direct mode, stimulus held one cycle each:
  - en=0 sel=0 -> out=0x0000.
  - en=0 sel=8 -> out=0x0000.
  - en=1, sel=2/5/7/14/12 -> out=0x0004/0x0020/0x0080/0x4000/0x1000, each one clock later; idx matches sel.
- Scan, last=3, start pulse -> out sequence 0001,0001,0002,0002,0004,0004,0008,0008,0001,…; busy=1 throughout; done never asserts.
- Sweep, last=2 -> 0001×2, 0002×2, 0004×2, then one cycle out=0, done=1, busy=0; then IDLE with direct decode of sel.
- Pause: scan, deassert en for 3 cycles during the first cycle of idx=1 -> out=0 for those cycles. On en return, out=0x0002 for 1 remaining cycle, then 0x0004.
- Conflicts:
  - start=1 and stop=1 in IDLE -> no start, busy stays 0.
  - stop at dwell expiry in RUN -> IDLE, out=0, no done.
  - start during RUN -> ignored.
  - Change last mid-run -> no effect.
- Reset: assert rst_n=0 between clock edges mid-sweep -> out=0, busy=0, done=0 immediately. After release, IDLE direct decode resumes.
